// File: rtl/fsm_rule_pkg.sv
// Shared defaults and width helper for the programmable rule-table FSM engine.
package fsm_rule_pkg;

  localparam int unsigned DEF_NI          = 27;
  localparam int unsigned DEF_NO          = 22;
  localparam int unsigned DEF_NUM_STATES  = 18;
  localparam int unsigned DEF_NUM_RULES   = 64;
  localparam int unsigned DEF_RESET_STATE = 0;
  localparam int unsigned DEF_REG_OUT     = 0;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsm_rule_match.sv
// Combinational rule matcher with first-match (lowest index wins) priority encoder.
module fsm_rule_match
  import fsm_rule_pkg::*;
#(
  parameter int unsigned NI         = DEF_NI,
  parameter int unsigned NUM_STATES = DEF_NUM_STATES,
  parameter int unsigned NUM_RULES  = DEF_NUM_RULES,
  localparam int unsigned SW        = clog2_min1(NUM_STATES),
  localparam int unsigned RW        = clog2_min1(NUM_RULES)
) (
  input  logic [NUM_RULES-1:0]          vld_i,
  input  logic [NUM_RULES-1:0][SW-1:0]  src_i,
  input  logic [NUM_RULES-1:0][NI-1:0]  mask_i,
  input  logic [NUM_RULES-1:0][NI-1:0]  val_i,
  input  logic [SW-1:0]                 state_i,
  input  logic [NI-1:0]                 x_i,
  output logic                          hit_o,
  output logic [RW-1:0]                 idx_o
);

  logic [NUM_RULES-1:0] match;

  // Per-rule match: valid, source state equal, cared input bits equal.
  always_comb begin
    match = '0;
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      match[r] = vld_i[r] && (src_i[r] == state_i) &&
                 (((x_i ^ val_i[r]) & mask_i[r]) == '0);
    end
  end

  // First match in ascending index order, like an if/else-if chain.
  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      if (match[r] && !found) begin
        found = 1'b1;
        idx_o = RW'(r);
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/fsm_rule_engine.sv
// Runtime-programmable Mealy FSM: rule table, state register, sticky error, output mode.
module fsm_rule_engine
  import fsm_rule_pkg::*;
#(
  parameter int unsigned NI          = DEF_NI,
  parameter int unsigned NO          = DEF_NO,
  parameter int unsigned NUM_STATES  = DEF_NUM_STATES,
  parameter int unsigned NUM_RULES   = DEF_NUM_RULES,
  parameter int unsigned RESET_STATE = DEF_RESET_STATE,
  parameter int unsigned REG_OUT     = DEF_REG_OUT,
  localparam int unsigned SW         = clog2_min1(NUM_STATES),
  localparam int unsigned RW         = clog2_min1(NUM_RULES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_en,
  input  logic [NI-1:0] x,
  output logic [NO-1:0] y,
  output logic [SW-1:0] state,
  output logic          hit,
  output logic [RW-1:0] rule_idx,
  output logic          err,
  input  logic          cfg_we,
  input  logic [RW-1:0] cfg_addr,
  input  logic          cfg_vld,
  input  logic [SW-1:0] cfg_src,
  input  logic [NI-1:0] cfg_mask,
  input  logic [NI-1:0] cfg_val,
  input  logic [SW-1:0] cfg_nxt,
  input  logic [NO-1:0] cfg_out
);

  typedef struct packed {
    logic          vld;
    logic [SW-1:0] src;
    logic [NI-1:0] mask;
    logic [NI-1:0] val;
    logic [SW-1:0] nxt;
    logic [NO-1:0] out;
  } rule_t;

  rule_t [NUM_RULES-1:0] tbl_q;
  logic  [SW-1:0]        state_q, state_d;
  logic                  err_q, err_d;

  logic [NUM_RULES-1:0]         m_vld;
  logic [NUM_RULES-1:0][SW-1:0] m_src;
  logic [NUM_RULES-1:0][NI-1:0] m_mask;
  logic [NUM_RULES-1:0][NI-1:0] m_val;
  logic                         m_hit;
  logic [RW-1:0]                m_idx;

  rule_t         win;
  logic          state_ok, nxt_ok, ev_hit, cfg_ok;
  logic [NO-1:0] y_c;
  logic          hit_c;
  logic [RW-1:0] idx_c;

  assign cfg_ok = cfg_we && (32'(cfg_addr) < NUM_RULES);

  // Rule table; clearing whole entries on reset leaves every rule invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_q <= '0;
    end else if (cfg_ok) begin
      tbl_q[cfg_addr] <= rule_t'{vld: cfg_vld, src: cfg_src, mask: cfg_mask,
                                 val: cfg_val, nxt: cfg_nxt, out: cfg_out};
    end
  end

  // Split the table into per-field arrays for the matcher.
  always_comb begin
    m_vld  = '0;
    m_src  = '0;
    m_mask = '0;
    m_val  = '0;
    for (int unsigned r = 0; r < NUM_RULES; r++) begin
      m_vld[r]  = tbl_q[r].vld;
      m_src[r]  = tbl_q[r].src;
      m_mask[r] = tbl_q[r].mask;
      m_val[r]  = tbl_q[r].val;
    end
  end

  fsm_rule_match #(
    .NI         (NI),
    .NUM_STATES (NUM_STATES),
    .NUM_RULES  (NUM_RULES)
  ) u_match (
    .vld_i   (m_vld),
    .src_i   (m_src),
    .mask_i  (m_mask),
    .val_i   (m_val),
    .state_i (state_q),
    .x_i     (x),
    .hit_o   (m_hit),
    .idx_o   (m_idx)
  );

  assign win      = tbl_q[m_idx];
  assign state_ok = 32'(state_q) < NUM_STATES;
  assign nxt_ok   = 32'(win.nxt) < NUM_STATES;
  assign ev_hit   = run_en && m_hit && state_ok;

  // Mealy outputs and next state; illegal targets fall back to RESET_STATE and flag err.
  always_comb begin
    y_c     = '0;
    hit_c   = 1'b0;
    idx_c   = '0;
    state_d = state_q;
    err_d   = err_q;
    if (!state_ok) begin
      state_d = SW'(RESET_STATE);
      err_d   = 1'b1;
    end else if (ev_hit) begin
      y_c   = win.out;
      hit_c = 1'b1;
      idx_c = m_idx;
      if (nxt_ok) begin
        state_d = win.nxt;
      end else begin
        state_d = SW'(RESET_STATE);
        err_d   = 1'b1;
      end
    end
  end

  // Present state and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SW'(RESET_STATE);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign err   = err_q;

  if (REG_OUT != 0) begin : g_reg_out
    logic [NO-1:0] y_q;
    logic          hit_q;
    logic [RW-1:0] idx_q;

    // Outputs captured on the same edge that advances the state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y_q   <= '0;
        hit_q <= 1'b0;
        idx_q <= '0;
      end else begin
        y_q   <= y_c;
        hit_q <= hit_c;
        idx_q <= idx_c;
      end
    end

    assign y        = y_q;
    assign hit      = hit_q;
    assign rule_idx = idx_q;
  end else begin : g_comb_out
    assign y        = y_c;
    assign hit      = hit_c;
    assign rule_idx = idx_c;
  end

endmodule

// File: tb/tb_fsm_rule_engine.sv
// Bench for fsm_rule_engine: combinational and registered-output instances share one stimulus.
module tb_fsm_rule_engine;

  localparam int unsigned NI = 8;
  localparam int unsigned NO = 8;
  localparam int unsigned NS = 3;
  localparam int unsigned NR = 8;
  localparam int unsigned RS = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_en = 1'b0;
  logic [7:0] x = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic       cfg_vld = 1'b0;
  logic [1:0] cfg_src = '0;
  logic [7:0] cfg_mask = '0;
  logic [7:0] cfg_val = '0;
  logic [1:0] cfg_nxt = '0;
  logic [7:0] cfg_out = '0;

  logic [7:0] y0, y1;
  logic [1:0] st0, st1;
  logic       hit0, hit1, err0, err1;
  logic [2:0] idx0, idx1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fsm_rule_engine #(.NI(NI), .NO(NO), .NUM_STATES(NS), .NUM_RULES(NR),
                    .RESET_STATE(RS), .REG_OUT(0)) dut_c (
    .clk(clk), .rst(rst), .run_en(run_en), .x(x), .y(y0), .state(st0), .hit(hit0),
    .rule_idx(idx0), .err(err0), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_vld(cfg_vld),
    .cfg_src(cfg_src), .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_nxt(cfg_nxt), .cfg_out(cfg_out));

  fsm_rule_engine #(.NI(NI), .NO(NO), .NUM_STATES(NS), .NUM_RULES(NR),
                    .RESET_STATE(RS), .REG_OUT(1)) dut_r (
    .clk(clk), .rst(rst), .run_en(run_en), .x(x), .y(y1), .state(st1), .hit(hit1),
    .rule_idx(idx1), .err(err1), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_vld(cfg_vld),
    .cfg_src(cfg_src), .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_nxt(cfg_nxt), .cfg_out(cfg_out));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: rule list scanned as a first-match chain.
  bit m_vld[NR];
  int m_src[NR], m_mask[NR], m_val[NR], m_nxt[NR], m_out[NR];
  int m_state = 0;
  bit m_err = 1'b0;
  int r_y = 0, r_idx = 0;
  bit r_hit = 1'b0;
  bit u_h;
  int u_i, u_v;

  function automatic void model_eval(output bit h, output int idx, output int yv);
    h = 1'b0; idx = 0; yv = 0;
    if (run_en && m_state < NS) begin
      for (int r = 0; r < NR; r++) begin
        if (!h && m_vld[r] && m_src[r] == m_state && (((int'(x) ^ m_val[r]) & m_mask[r]) == 0)) begin
          h = 1'b1; idx = r; yv = m_out[r];
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) m_vld[r] = 1'b0;
      m_state = RS; m_err = 1'b0; r_y = 0; r_hit = 1'b0; r_idx = 0;
    end else begin
      model_eval(u_h, u_i, u_v);
      if (m_state >= NS) begin
        m_state = RS; m_err = 1'b1;
      end else if (u_h) begin
        if (m_nxt[u_i] >= NS) begin m_state = RS; m_err = 1'b1; end
        else m_state = m_nxt[u_i];
      end
      r_y = u_v; r_hit = u_h; r_idx = u_i;
      if (cfg_we && int'(cfg_addr) < NR) begin
        m_vld[cfg_addr] = cfg_vld;  m_src[cfg_addr] = int'(cfg_src);
        m_mask[cfg_addr] = int'(cfg_mask); m_val[cfg_addr] = int'(cfg_val);
        m_nxt[cfg_addr] = int'(cfg_nxt); m_out[cfg_addr] = int'(cfg_out);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  bit c_h;
  int c_i, c_v;
  always @(negedge clk) begin
    model_eval(c_h, c_i, c_v);
    chk("y_comb", int'(y0), c_v);
    chk("hit_comb", int'(hit0), int'(c_h));
    chk("idx_comb", int'(idx0), c_i);
    chk("state_comb", int'(st0), m_state);
    chk("err_comb", int'(err0), int'(m_err));
    chk("y_reg", int'(y1), r_y);
    chk("hit_reg", int'(hit1), int'(r_hit));
    chk("idx_reg", int'(idx1), r_idx);
    chk("state_reg", int'(st1), m_state);
    chk("err_reg", int'(err1), int'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input bit v, input int s, input int m, input int vl,
                    input int n, input int o);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_vld = v; cfg_src = 2'(s);
    cfg_mask = 8'(m); cfg_val = 8'(vl); cfg_nxt = 2'(n); cfg_out = 8'(o);
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 1'b0; run_en = 1'b1; x = 8'hFF;
    repeat (5) begin
      #1;
      chk("empty_state", int'(st0), 0); chk("empty_y", int'(y0), 0);
      chk("empty_hit", int'(hit0), 0); chk("empty_err", int'(err0), 0);
      tick();
    end

    run_en = 1'b0; x = 8'h00;
    wr(0, 1, 0, 'h03, 'h01, 1, 'h12);
    wr(1, 1, 0, 'h01, 'h01, 2, 'h40);
    wr(3, 1, 1, 'h00, 'h00, 0, 'h77);
    wr(4, 1, 2, 'h80, 'h80, 0, 'h55);

    run_en = 1'b1; x = 8'h01; #1;
    chk("r0_y", int'(y0), 'h12); chk("r0_idx", int'(idx0), 0); chk("r0_hit", int'(hit0), 1);
    chk("r0_yreg_early", int'(y1), 0);
    tick();
    chk("r0_state", int'(st0), 1); chk("r0_yreg", int'(y1), 'h12); chk("r0_streg", int'(st1), 1);

    x = 8'h03; tick();
    chk("r3_back", int'(st0), 0);
    chk("r1_y", int'(y0), 'h40); chk("r1_idx", int'(idx0), 1);
    tick();
    chk("r1_state", int'(st0), 2);
    x = 8'h80; tick();
    chk("r4_back", int'(st0), 0);

    run_en = 1'b0; x = 8'h01;
    repeat (3) begin
      #1;
      chk("frz_y", int'(y0), 0); chk("frz_hit", int'(hit0), 0); chk("frz_state", int'(st0), 0);
      tick();
    end
    run_en = 1'b1; #1;
    chk("resume_y", int'(y0), 'h12); chk("resume_hit", int'(hit0), 1);
    tick();
    chk("resume_state", int'(st0), 1);
    x = 8'h03; tick();

    x = 8'h01;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_vld = 1'b1; cfg_src = 2'd0;
    cfg_mask = 8'h03; cfg_val = 8'h01; cfg_nxt = 2'd1; cfg_out = 8'hAA;
    #1;
    chk("coll_old_y", int'(y0), 'h12);
    tick();
    cfg_we = 1'b0;
    chk("coll_state", int'(st0), 1);
    x = 8'h03; tick();
    x = 8'h01; #1;
    chk("coll_new_y", int'(y0), 'hAA);
    tick();
    x = 8'h03; tick();
    chk("coll_back", int'(st0), 0);

    run_en = 1'b0;
    wr(0, 0, 0, 0, 0, 0, 0);
    wr(1, 0, 0, 0, 0, 0, 0);
    wr(2, 1, 0, 'h00, 'h00, 3, 'h01);
    run_en = 1'b1; x = 8'h5A; #1;
    chk("ill_y", int'(y0), 'h01); chk("ill_idx", int'(idx0), 2); chk("ill_hit", int'(hit0), 1);
    tick();
    chk("ill_state", int'(st0), 0); chk("ill_err", int'(err0), 1); chk("ill_yreg", int'(y1), 'h01);
    run_en = 1'b0;
    repeat (2) begin
      tick();
      chk("err_sticky", int'(err0), 1);
    end

    wr(2, 0, 0, 0, 0, 0, 0);
    wr(1, 1, 0, 'h01, 'h01, 2, 'h40);
    run_en = 1'b1; x = 8'h01; tick();
    chk("pre_rst_state", int'(st0), 2);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", int'(st0), 0); chk("arst_y", int'(y0), 0); chk("arst_hit", int'(hit0), 0);
    chk("arst_err", int'(err0), 0); chk("arst_yreg", int'(y1), 0);
    #4 rst = 1'b0;
    #1;
    chk("post_rst_hit", int'(hit0), 0); chk("post_rst_y", int'(y0), 0);
    tick();
    chk("post_rst_hit2", int'(hit0), 0); chk("post_rst_state", int'(st0), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
